// File: rtl/dmem_access_unit.sv
// MEM-stage load/store initiator for a negedge-sampled word memory; sub-word stores are read-modify-write.
// Latency: 1 (misaligned), 2 (load / word store), 3 (byte/half store); req_ready only in IDLE, so stall holds the pipe.
module dmem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        stall,
  output logic        readEn,
  output logic        writeEn,
  output logic [31:0] address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              uns_q, uns_d;
  logic              mis_q, mis_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       merge_q, merge_d;

  logic [4:0]  lane_sh;
  logic [31:0] lane;
  logic [31:0] lane_mask;
  logic [31:0] load_ext;
  logic [31:0] store_merge;
  logic        req_mis;

  // Byte-address bits above the memory span wrap and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    lane_sh   = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    if (size_q == 2'b00) begin
      lane_sh   = {addr_q[1:0], 3'b000};
      lane_mask = 32'h0000_00FF << lane_sh;
    end else if (size_q == 2'b01) begin
      lane_sh   = {addr_q[1], 4'b0000};
      lane_mask = 32'h0000_FFFF << lane_sh;
    end
    lane = ReadData >> lane_sh;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: load_ext = ReadData;
    endcase
    store_merge = (ReadData & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    req_mis = ((req_size == 2'b01) && req_addr[0]) ||
              (req_size[1] && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W+1:0];
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          mis_d   = req_mis;
          if (req_mis)         state_d = RESP;
          else if (!req_write) state_d = READ;
          else if (req_size[1]) state_d = WRITE;
          else                 state_d = RMW_RD;
        end
      end
      READ: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        merge_d = store_merge;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Memory strobes depend only on registered state so they are settled by the negedge.
  assign readEn    = ~rst & ((state_q == READ) || (state_q == RMW_RD));
  assign writeEn   = ~rst & ((state_q == WRITE) || (state_q == RMW_WR));
  assign address   = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign WriteData = (state_q == RMW_WR) ? merge_q : wdata_q;

  assign req_ready       = (state_q == IDLE);
  assign stall           = ~req_ready;
  assign resp_valid      = (state_q == RESP);
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_rdata      = (resp_valid && !write_q && !mis_q) ? rdata_q : 32'd0;

endmodule
